multicycle_controller: RTL and testbench



---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: phase codes, opcode/funct
// values, ALU function codes and PC-control classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_HALT   = 3'd7
    } phase_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_JREG  = 6'b111111;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [5:0] ALU_NONE = 6'b000000;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_SLT  = 6'b101010;

    localparam logic [1:0] CP_SEQ    = 2'b00;
    localparam logic [1:0] CP_REG    = 2'b01;
    localparam logic [1:0] CP_JUMP   = 2'b10;
    localparam logic [1:0] CP_BRANCH = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to ALU controls, PC class,
// instruction class bits and an illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opecode_i,
    input  logic [5:0] funct_i,
    output logic [5:0] alu_func_o,
    output logic       reorim_o,
    output logic [1:0] cp_type_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       is_link_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_rtype_o,
    output logic       illegal_o
);

    always_comb begin
        alu_func_o  = ALU_NONE;
        reorim_o    = 1'b0;
        cp_type_o   = CP_SEQ;
        is_branch_o = 1'b0;
        is_jump_o   = 1'b0;
        is_link_o   = 1'b0;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_rtype_o  = 1'b0;
        illegal_o   = 1'b0;
        case (opecode_i)
            OP_RTYPE: begin
                alu_func_o = funct_i;
                is_rtype_o = 1'b1;
                if (funct_i == FN_JR) cp_type_o = CP_REG;
            end
            OP_ADDI: begin alu_func_o = ALU_ADD; reorim_o = 1'b1; end
            OP_ANDI: begin alu_func_o = ALU_AND; reorim_o = 1'b1; end
            OP_ORI:  begin alu_func_o = ALU_OR;  reorim_o = 1'b1; end
            OP_SLTI: begin alu_func_o = ALU_SLT; reorim_o = 1'b1; end
            OP_BEQ, OP_BNE: begin
                alu_func_o  = ALU_SUB;
                reorim_o    = 1'b1;
                cp_type_o   = CP_BRANCH;
                is_branch_o = 1'b1;
            end
            OP_J: begin
                cp_type_o = CP_JUMP;
                is_jump_o = 1'b1;
            end
            OP_JAL: begin
                cp_type_o = CP_JUMP;
                is_jump_o = 1'b1;
                is_link_o = 1'b1;
            end
            OP_JREG: cp_type_o = CP_REG;
            OP_LW: begin alu_func_o = ALU_ADD; reorim_o = 1'b1; is_load_o  = 1'b1; end
            OP_SW: begin alu_func_o = ALU_ADD; reorim_o = 1'b1; is_store_o = 1'b1; end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: phase FSM, memory timeout counter and registered
// datapath controls. Decode results are latched on the DECODE->EXEC edge.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int STEP_EN     = 0,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opecode,
    input  logic [5:0] funct,
    input  logic       zflag,
    input  logic       mem_ready,
    input  logic       step,
    output logic [5:0] alu_func,
    output logic       reorim,
    output logic [1:0] cp_type,
    output logic [1:0] pc_src,
    output logic       write_pc,
    output logic       write_reg,
    output logic       write_lr,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] phase,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal
);

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(MEM_TIMEOUT - 1);
    localparam phase_e          PH_NEXT  = (STEP_EN != 0) ? PH_IDLE : PH_FETCH;
    localparam logic            NEXT_REQ = (STEP_EN == 0);

    logic [5:0] dec_alu_func;
    logic       dec_reorim;
    logic [1:0] dec_cp_type;
    logic       dec_branch, dec_jump, dec_link, dec_load, dec_store;
    logic       dec_rtype_unused;
    logic       dec_illegal;

    ctrl_decode u_decode (
        .opecode_i   (opecode),
        .funct_i     (funct),
        .alu_func_o  (dec_alu_func),
        .reorim_o    (dec_reorim),
        .cp_type_o   (dec_cp_type),
        .is_branch_o (dec_branch),
        .is_jump_o   (dec_jump),
        .is_link_o   (dec_link),
        .is_load_o   (dec_load),
        .is_store_o  (dec_store),
        .is_rtype_o  (dec_rtype_unused),
        .illegal_o   (dec_illegal)
    );

    phase_e          phase_q;
    logic [5:0]      alu_func_q;
    logic            reorim_q;
    logic [1:0]      cp_type_q;
    logic            br_jmp_q, load_q, store_q;
    logic            write_pc_q, write_reg_q, write_lr_q;
    logic            mem_req_q, mem_we_q;
    logic            halted_q, bus_err_q, illegal_q;
    logic [TO_W-1:0] to_cnt_q;

    logic stall, timeout_hit;
    assign stall       = mem_req_q && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && stall && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            alu_func_q  <= ALU_NONE;
            reorim_q    <= 1'b0;
            cp_type_q   <= CP_SEQ;
            br_jmp_q    <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            write_pc_q  <= 1'b0;
            write_reg_q <= 1'b0;
            write_lr_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            illegal_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            write_pc_q  <= 1'b0;
            write_reg_q <= 1'b0;
            write_lr_q  <= 1'b0;
            case (phase_q)
                PH_IDLE: begin
                    if (STEP_EN == 0 || step) begin
                        phase_q   <= PH_FETCH;
                        mem_req_q <= 1'b1;
                        to_cnt_q  <= '0;
                    end
                end
                PH_FETCH: begin
                    if (mem_ready) begin
                        phase_q   <= PH_DECODE;
                        mem_req_q <= 1'b0;
                    end else if (timeout_hit) begin
                        phase_q   <= PH_HALT;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                PH_DECODE: begin
                    if (dec_illegal) begin
                        phase_q   <= PH_HALT;
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        phase_q    <= PH_EXEC;
                        alu_func_q <= dec_alu_func;
                        reorim_q   <= dec_reorim;
                        cp_type_q  <= dec_cp_type;
                        br_jmp_q   <= dec_branch || dec_jump;
                        load_q     <= dec_load;
                        store_q    <= dec_store;
                        // Branches and jumps finish in EXEC, so their PC/LR pulses land there.
                        write_pc_q <= dec_branch || dec_jump;
                        write_lr_q <= dec_link;
                    end
                end
                PH_EXEC: begin
                    if (br_jmp_q) begin
                        phase_q   <= PH_NEXT;
                        mem_req_q <= NEXT_REQ;
                        to_cnt_q  <= '0;
                    end else if (load_q || store_q) begin
                        phase_q   <= PH_MEM;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= store_q;
                        to_cnt_q  <= '0;
                    end else begin
                        phase_q     <= PH_WB;
                        write_pc_q  <= 1'b1;
                        write_reg_q <= 1'b1;
                    end
                end
                PH_MEM: begin
                    if (mem_ready) begin
                        mem_we_q <= 1'b0;
                        if (load_q) begin
                            phase_q     <= PH_WB;
                            mem_req_q   <= 1'b0;
                            write_pc_q  <= 1'b1;
                            write_reg_q <= 1'b1;
                        end else begin
                            phase_q   <= PH_NEXT;
                            mem_req_q <= NEXT_REQ;
                            to_cnt_q  <= '0;
                        end
                    end else if (timeout_hit) begin
                        phase_q   <= PH_HALT;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                PH_WB: begin
                    phase_q   <= PH_NEXT;
                    mem_req_q <= NEXT_REQ;
                    to_cnt_q  <= '0;
                end
                PH_HALT: phase_q <= PH_HALT;
                default: begin
                    phase_q  <= PH_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // A store ends on the acknowledge cycle itself, so its PC pulse cannot be registered ahead.
    assign write_pc  = write_pc_q || ((phase_q == PH_MEM) && store_q && mem_ready && !rst);
    assign ir_write  = (phase_q == PH_FETCH) && mem_ready && !rst;
    assign pc_src    = ((cp_type_q == CP_BRANCH) && !(zflag ^ opecode[0])) ? CP_SEQ : cp_type_q;
    assign alu_func  = alu_func_q;
    assign reorim    = reorim_q;
    assign cp_type   = cp_type_q;
    assign write_reg = write_reg_q;
    assign write_lr  = write_lr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign phase     = phase_q;
    assign halted    = halted_q;
    assign bus_err   = bus_err_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: free-running (timeout 4) and single-step
// instances driven by randomized instruction plans against a phase-level model.
module tb_multicycle_controller;

    localparam logic [2:0] PH_I = 3'd0, PH_F = 3'd1, PH_D = 3'd2, PH_E = 3'd3,
                           PH_M = 3'd4, PH_W = 3'd5, PH_H = 3'd7;
    localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LW = 3, K_SW = 4, K_ILL = 5;

    typedef struct {
        logic [2:0] ph;
        logic       rdy;
        logic       stp;
        logic       last;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, zflag, mem_ready, step;
    logic [5:0] opecode, funct;

    logic [1:0][5:0] alu_func_w;
    logic [1:0][1:0] cp_type_w, pc_src_w;
    logic [1:0][2:0] phase_w;
    logic [1:0]      reorim_w, write_pc_w, write_reg_w, write_lr_w, ir_write_w;
    logic [1:0]      mem_req_w, mem_we_w, halted_w, bus_err_w, illegal_w;

    int sel = 0;
    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.STEP_EN(0), .MEM_TIMEOUT(4), .TO_W(3)) dut0 (
        .clk(clk), .rst(rst), .opecode(opecode), .funct(funct), .zflag(zflag),
        .mem_ready(mem_ready), .step(step),
        .alu_func(alu_func_w[0]), .reorim(reorim_w[0]), .cp_type(cp_type_w[0]),
        .pc_src(pc_src_w[0]), .write_pc(write_pc_w[0]), .write_reg(write_reg_w[0]),
        .write_lr(write_lr_w[0]), .ir_write(ir_write_w[0]), .mem_req(mem_req_w[0]),
        .mem_we(mem_we_w[0]), .phase(phase_w[0]), .halted(halted_w[0]),
        .bus_err(bus_err_w[0]), .illegal(illegal_w[0])
    );

    multicycle_controller #(.STEP_EN(1), .MEM_TIMEOUT(0), .TO_W(8)) dut1 (
        .clk(clk), .rst(rst), .opecode(opecode), .funct(funct), .zflag(zflag),
        .mem_ready(mem_ready), .step(step),
        .alu_func(alu_func_w[1]), .reorim(reorim_w[1]), .cp_type(cp_type_w[1]),
        .pc_src(pc_src_w[1]), .write_pc(write_pc_w[1]), .write_reg(write_reg_w[1]),
        .write_lr(write_lr_w[1]), .ir_write(ir_write_w[1]), .mem_req(mem_req_w[1]),
        .mem_we(mem_we_w[1]), .phase(phase_w[1]), .halted(halted_w[1]),
        .bus_err(bus_err_w[1]), .illegal(illegal_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (dut%0d op %b t=%0t)",
                     tag, got, exp, sel, opecode, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rand_funct();
        if ($urandom_range(0, 3) == 0) return 6'b001000;
        return 6'($urandom);
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [12];
        ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000100,
                6'b000101, 6'b000010, 6'b000011, 6'b111111, 6'b100011, 6'b101011};
        return ops[$urandom_range(0, 11)];
    endfunction

    // Reference decode table straight from the instruction set description.
    task automatic ref_dec(input logic [5:0] op, input logic [5:0] fn, output logic [5:0] alu,
                           output logic reo, output logic [1:0] cp, output int kind);
        alu = 6'b0; reo = 1'b0; cp = 2'b00; kind = K_ALU;
        case (op)
            6'b000000: begin alu = fn; if (fn == 6'b001000) cp = 2'b01; end
            6'b001000: begin alu = 6'b100000; reo = 1'b1; end
            6'b001100: begin alu = 6'b100100; reo = 1'b1; end
            6'b001101: begin alu = 6'b100101; reo = 1'b1; end
            6'b001010: begin alu = 6'b101010; reo = 1'b1; end
            6'b000100, 6'b000101: begin alu = 6'b100010; reo = 1'b1; cp = 2'b11; kind = K_BR; end
            6'b000010, 6'b000011: begin cp = 2'b10; kind = K_JMP; end
            6'b111111: cp = 2'b01;
            6'b100011: begin alu = 6'b100000; reo = 1'b1; kind = K_LW; end
            6'b101011: begin alu = 6'b100000; reo = 1'b1; kind = K_SW; end
            default:   kind = K_ILL;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = rb(); step = rb();
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; step = 1'b0;
        #1;
        chk("rst_phase", phase_w[sel], PH_I);
        chk("rst_ctl", {alu_func_w[sel], reorim_w[sel], cp_type_w[sel], pc_src_w[sel]}, 0);
        chk("rst_pulses", {write_pc_w[sel], write_reg_w[sel], write_lr_w[sel], ir_write_w[sel],
                           mem_req_w[sel], mem_we_w[sel]}, 0);
        chk("rst_flags", {halted_w[sel], bus_err_w[sel], illegal_w[sel]}, 0);
    endtask

    // Builds the expected phase sequence for one instruction, then drives and checks it cycle by cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input bit smode);
        logic [5:0] e_alu;
        logic       e_reo;
        logic [1:0] e_cp, e_pc;
        int         kind;
        cyc_t       plan[$];
        cyc_t       c;
        ref_dec(op, fn, e_alu, e_reo, e_cp, kind);
        e_pc = (e_cp == 2'b11 && (z ^ op[0]) == 1'b0) ? 2'b00 : e_cp;
        if (smode) begin
            repeat ($urandom_range(0, 2)) plan.push_back('{PH_I, rb(), 1'b0, 1'b0});
            plan.push_back('{PH_I, rb(), 1'b1, 1'b0});
        end
        repeat (fw) plan.push_back('{PH_F, 1'b0, rb(), 1'b0});
        plan.push_back('{PH_F, 1'b1, rb(), 1'b0});
        plan.push_back('{PH_D, rb(), rb(), 1'b0});
        plan.push_back('{PH_E, rb(), smode ? 1'b1 : rb(), (kind == K_BR || kind == K_JMP)});
        if (kind == K_LW || kind == K_SW) begin
            repeat (mw) plan.push_back('{PH_M, 1'b0, rb(), 1'b0});
            plan.push_back('{PH_M, 1'b1, rb(), (kind == K_SW)});
        end
        if (kind == K_ALU || kind == K_LW) plan.push_back('{PH_W, rb(), rb(), 1'b1});
        opecode = op; funct = fn; zflag = z;
        foreach (plan[i]) begin
            c = plan[i];
            @(negedge clk);
            mem_ready = c.rdy; step = c.stp;
            #1;
            chk("phase", phase_w[sel], c.ph);
            chk("mem_req", mem_req_w[sel], (c.ph == PH_F || c.ph == PH_M));
            chk("mem_we", mem_we_w[sel], (c.ph == PH_M && kind == K_SW));
            chk("ir_write", ir_write_w[sel], (c.ph == PH_F && c.rdy));
            chk("write_reg", write_reg_w[sel], (c.ph == PH_W));
            chk("write_lr", write_lr_w[sel], (c.ph == PH_E && op == 6'b000011));
            chk("write_pc", write_pc_w[sel], c.last);
            if (c.ph == PH_E || c.ph == PH_M || c.ph == PH_W) begin
                chk("alu_func", alu_func_w[sel], e_alu);
                chk("reorim", reorim_w[sel], e_reo);
                chk("cp_type", cp_type_w[sel], e_cp);
            end
            if (c.last) begin
                chk("pc_src", pc_src_w[sel], e_pc);
                chk("flags", {halted_w[sel], bus_err_w[sel], illegal_w[sel]}, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; step = 1'b0; zflag = 1'b0;
        opecode = 6'b0; funct = 6'b0;

        sel = 0;
        do_reset();
        run_instr(6'b001000, rand_funct(), 1'b0, 0, 0, 1'b0);
        run_instr(6'b000100, rand_funct(), 1'b1, 0, 0, 1'b0);
        run_instr(6'b000101, rand_funct(), 1'b1, 0, 0, 1'b0);
        run_instr(6'b000011, rand_funct(), rb(), 0, 0, 1'b0);
        run_instr(6'b100011, rand_funct(), rb(), 0, 3, 1'b0);
        run_instr(6'b101011, rand_funct(), rb(), 0, 0, 1'b0);
        run_instr(6'b000000, 6'b001000, rb(), 0, 0, 1'b0);
        run_instr(6'b001101, rand_funct(), rb(), 3, 0, 1'b0);
        run_instr(6'b101011, rand_funct(), rb(), 2, 3, 1'b0);
        repeat (40)
            run_instr(pick_op(), rand_funct(), rb(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

        // Reset asserted mid-stall with an acknowledge in the same cycle.
        do_reset();
        @(negedge clk); mem_ready = 1'b0; #1; chk("stall_phase", phase_w[0], PH_F);
        @(negedge clk); mem_ready = 1'b0; #1; chk("stall_phase", phase_w[0], PH_F);
        @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
        chk("ir_write_under_rst", ir_write_w[0], 1'b0);
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        chk("rst_mid_stall_phase", phase_w[0], PH_I);
        chk("rst_mid_stall_req", mem_req_w[0], 1'b0);
        run_instr(pick_op(), rand_funct(), rb(), 1, 1, 1'b0);

        // Four stalled fetch cycles trip the timeout.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            chk("to_phase", phase_w[0], PH_F);
            chk("to_bus_err_early", bus_err_w[0], 1'b0);
        end
        @(negedge clk); #1;
        chk("to_phase_halt", phase_w[0], PH_H);
        chk("to_bus_err", bus_err_w[0], 1'b1);
        chk("to_halted", halted_w[0], 1'b1);
        chk("to_mem_req", mem_req_w[0], 1'b0);
        repeat (2) begin
            @(negedge clk); mem_ready = 1'b1; step = 1'b1; #1;
            chk("halt_absorb", phase_w[0], PH_H);
        end

        // Undecodable opcode halts after DECODE.
        do_reset();
        opecode = 6'b010000; funct = rand_funct();
        @(negedge clk); mem_ready = 1'b1; #1; chk("ill_fetch", phase_w[0], PH_F);
        @(negedge clk); mem_ready = rb(); #1;
        chk("ill_decode", phase_w[0], PH_D);
        chk("ill_early", illegal_w[0], 1'b0);
        @(negedge clk); #1;
        chk("ill_phase", phase_w[0], PH_H);
        chk("ill_flag", illegal_w[0], 1'b1);
        chk("ill_halted", halted_w[0], 1'b1);
        chk("ill_bus_err", bus_err_w[0], 1'b0);
        chk("ill_write_pc", write_pc_w[0], 1'b0);
        @(negedge clk); mem_ready = 1'b1; step = 1'b1; #1;
        chk("ill_absorb", phase_w[0], PH_H);
        do_reset();

        // Single-step instance with the timeout disabled.
        sel = 1;
        do_reset();
        run_instr(6'b001000, rand_funct(), 1'b0, 0, 0, 1'b1);
        run_instr(6'b100011, rand_funct(), rb(), 6, 5, 1'b1);
        run_instr(6'b000100, rand_funct(), 1'b0, 0, 0, 1'b1);
        repeat (10)
            run_instr(pick_op(), rand_funct(), rb(), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
        repeat (3) begin
            @(negedge clk); step = 1'b0; mem_ready = rb(); #1;
            chk("step_idle_hold", phase_w[1], PH_I);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
